// File: rtl/flex_counter_ext.sv
// Parametrised up/down counter with load, wrap/saturate select, a one-cycle wrap pulse
// and a wrap-event counter with a sticky overflow bit.
module flex_counter_ext #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int NUM_WRAP_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     count_enable_i,
    input  logic                     count_down_i,
    input  logic                     saturate_i,
    input  logic                     load_i,
    input  logic [NUM_CNT_BITS-1:0]  load_val_i,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val_i,
    output logic [NUM_CNT_BITS-1:0]  count_out_o,
    output logic                     rollover_flag_o,
    output logic                     rollover_pulse_o,
    output logic [NUM_WRAP_BITS-1:0] wrap_count_o,
    output logic                     wrap_overflow_o
);

    localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
    localparam logic [NUM_WRAP_BITS-1:0] WRAP_ONE = NUM_WRAP_BITS'(1);

    logic [NUM_CNT_BITS-1:0]  count_q, count_d;
    logic                     flag_q, flag_d;
    logic                     pulse_q, pulse_d;
    logic [NUM_WRAP_BITS-1:0] wrap_cnt_q, wrap_cnt_d;
    logic                     ovf_q, ovf_d;

    logic [NUM_CNT_BITS-1:0]  next_cnt;
    logic                     wrap_evt;
    logic [NUM_CNT_BITS:0]    cnt_ext;
    logic [NUM_CNT_BITS:0]    rv_ext;

    assign cnt_ext = {1'b0, count_q};
    assign rv_ext  = {1'b0, rollover_val_i};

    // Count step assuming count_enable is the winning action this edge.
    always_comb begin
        next_cnt = count_q;
        wrap_evt = 1'b0;
        if (rollover_val_i == '0) begin
            next_cnt = count_q;
        end else if (!count_down_i) begin
            if (cnt_ext < rv_ext) begin
                next_cnt = count_q + CNT_ONE;
            end else if (!saturate_i) begin
                next_cnt = CNT_ONE;
                wrap_evt = 1'b1;
            end else begin
                next_cnt = rollover_val_i;
            end
        end else begin
            if (cnt_ext > rv_ext) begin
                next_cnt = rollover_val_i;
            end else if (count_q > CNT_ONE) begin
                next_cnt = count_q - CNT_ONE;
            end else if (!saturate_i) begin
                next_cnt = rollover_val_i;
                wrap_evt = 1'b1;
            end else begin
                next_cnt = count_q;
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        flag_d     = flag_q;
        pulse_d    = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        ovf_d      = ovf_q;
        if (clear_i) begin
            count_d    = '0;
            flag_d     = 1'b0;
            wrap_cnt_d = '0;
            ovf_d      = 1'b0;
        end else if (load_i) begin
            count_d = load_val_i;
            flag_d  = (load_val_i == rollover_val_i);
        end else if (count_enable_i) begin
            count_d = next_cnt;
            flag_d  = (next_cnt == rollover_val_i);
            if (wrap_evt) begin
                pulse_d    = 1'b1;
                wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
                ovf_d      = ovf_q | (&wrap_cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            flag_q     <= 1'b0;
            pulse_q    <= 1'b0;
            wrap_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            flag_q     <= flag_d;
            pulse_q    <= pulse_d;
            wrap_cnt_q <= wrap_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign count_out_o      = count_q;
    assign rollover_flag_o  = flag_q;
    assign rollover_pulse_o = pulse_q;
    assign wrap_count_o     = wrap_cnt_q;
    assign wrap_overflow_o  = ovf_q;

endmodule

// File: tb/tb_flex_counter_ext.sv
// Directed table-driven bench for flex_counter_ext, 4-bit count and 2-bit wrap counter
// so the wrap-counter overflow is reachable in a handful of cycles.
module tb_flex_counter_ext;

    localparam int CB = 4;
    localparam int WB = 2;

    logic          clk;
    logic          rst, clear, en, dn, sat, ld;
    logic [CB-1:0] lv, rv;
    logic [CB-1:0] count_out;
    logic          flag, pulse, ovf;
    logic [WB-1:0] wc;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic          rst, clr, ld, en, dn, sat;
        logic [CB-1:0] lv, rv;
        logic [CB-1:0] c;
        logic          f, p;
        logic [WB-1:0] wc;
        logic          o;
    } vec_t;

    vec_t vq[$];

    flex_counter_ext #(.NUM_CNT_BITS(CB), .NUM_WRAP_BITS(WB)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .count_enable_i(en),
        .count_down_i(dn), .saturate_i(sat), .load_i(ld), .load_val_i(lv),
        .rollover_val_i(rv), .count_out_o(count_out), .rollover_flag_o(flag),
        .rollover_pulse_o(pulse), .wrap_count_o(wc), .wrap_overflow_o(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic c, input logic l, input logic e,
                       input logic d, input logic s, input int lval, input int rval,
                       input int ec, input logic ef, input logic ep, input int ew,
                       input logic eo);
        vec_t v;
        v.rst = r; v.clr = c; v.ld = l; v.en = e; v.dn = d; v.sat = s;
        v.lv = CB'(lval); v.rv = CB'(rval);
        v.c = CB'(ec); v.f = ef; v.p = ep; v.wc = WB'(ew); v.o = eo;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic c, input logic l, input logic e,
                         input logic d, input logic s, input logic [CB-1:0] lval,
                         input logic [CB-1:0] rval);
        rst = r; clear = c; ld = l; en = e; dn = d; sat = s; lv = lval; rv = rval;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [CB-1:0] ec,
                         input logic ef, input logic ep, input logic [WB-1:0] ew,
                         input logic eo);
        n_tests++;
        if ({count_out, flag, pulse, wc, ovf} !== {ec, ef, ep, ew, eo}) begin
            n_fail++;
            $display("FAIL %s[%0d]: got cnt=%0d flag=%0b pulse=%0b wc=%0d ovf=%0b, want cnt=%0d flag=%0b pulse=%0b wc=%0d ovf=%0b",
                     name, idx, count_out, flag, pulse, wc, ovf, ec, ef, ep, ew, eo);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; en = 1'b0; dn = 1'b0; sat = 1'b0; ld = 1'b0;
        lv = '0; rv = '0;

        //   rst clr ld en dn sat lv  rv   cnt f  p  wc o
        add(1, 0, 0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 0);
        // up wrap at 5
        add(0, 0, 0, 1, 0, 0, 0, 5,   1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   2, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   3, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   4, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   5, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   2, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   3, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   4, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   5, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   1, 0, 1, 2, 0);
        add(0, 0, 0, 1, 0, 0, 0, 5,   2, 0, 0, 2, 0);
        // down wrap then saturate
        add(0, 1, 0, 0, 0, 0, 0, 5,   0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 3, 4,   3, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 4,   2, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 4,   1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 4,   4, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0, 4,   3, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0, 4,   2, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0, 4,   1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0, 4,   1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0, 4,   1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0, 4,   1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0, 4,   4, 1, 1, 2, 0);
        // down from above terminal, then direction change
        add(0, 0, 1, 0, 0, 0, 9, 4,   9, 0, 0, 2, 0);
        add(0, 0, 0, 1, 1, 0, 0, 4,   4, 1, 0, 2, 0);
        add(0, 0, 0, 1, 0, 0, 0, 4,   1, 0, 1, 3, 0);
        // rollover_val == 0 holds
        add(0, 0, 1, 0, 0, 0, 3, 0,   3, 0, 0, 3, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0,   3, 0, 0, 3, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0,   3, 0, 0, 3, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // priority: clear > load > enable, load > enable
        add(0, 1, 1, 1, 0, 0, 7, 15,  0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 7, 15,  7, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 15, 15, 15, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 15,  15, 1, 0, 0, 0);
        // wrap counter overflow at 4th wrap
        add(0, 0, 1, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1,   1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1,   1, 1, 1, 2, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1,   1, 1, 1, 3, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1,   1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1,   1, 1, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].clr, vq[i].ld, vq[i].en, vq[i].dn, vq[i].sat,
                  vq[i].lv, vq[i].rv);
            check("vec", i, vq[i].c, vq[i].f, vq[i].p, vq[i].wc, vq[i].o);
        end

        // full-scale up saturate, then one wrap-mode step
        drive(0, 1, 0, 0, 0, 0, 4'd0, 4'd15);
        for (int i = 0; i < 20; i++) begin
            int exp_c;
            exp_c = (i < 15) ? i + 1 : 15;
            drive(0, 0, 0, 1, 0, 1, 4'd0, 4'd15);
            check("sat_up", i, CB'(exp_c), (exp_c == 15), 1'b0, 2'd0, 1'b0);
        end
        drive(0, 0, 0, 1, 0, 0, 4'd0, 4'd15);
        check("full_wrap", 0, 4'd1, 1'b0, 1'b1, 2'd1, 1'b0);

        // reset in the middle of counting, then resume
        drive(0, 1, 0, 0, 0, 0, 4'd0, 4'd5);
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 4'd0, 4'd5);
            check("pre_rst", i, CB'(i), 1'b0, 1'b0, 2'd0, 1'b0);
        end
        drive(1, 0, 0, 1, 0, 0, 4'd0, 4'd5);
        check("mid_rst", 0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            drive(0, 0, 0, 1, 0, 0, 4'd0, 4'd5);
            check("post_rst", i, CB'(i), 1'b0, 1'b0, 2'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
